bsg_tag_demux_fifos: RTL
========================

# bsg_tag_demux_fifos

Downstream consumer of the 2-input round-robin arbiter. Takes the arbiter's single output stream (valid, data, tag) and retires each word with a yumi. Steers each word by tag into one of `num_out_p` per-channel FIFOs, each drained by its own valid/ready consumer. The FIFOs absorb per-destination backpressure, so a stalled consumer never blocks words bound for the other channels.

## Interface
Parameters:
- `width_p`, 16, data word width (matches the arbiter's `data_o`).
- `num_out_p`, 2, number of output channels; legal range 2..8.
- `els_p`, 2, entries per channel FIFO; power of two, 2..16.
- `tag_width_lp`, `$clog2(num_out_p)`, derived; not overridable.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `v_i`  in  1  upstream word valid (arbiter `v_o`).
- `data_i`  in  `width_p`  upstream data.
- `tag_i`  in  `tag_width_lp`  destination channel.
- `yumi_o`  out  1  word consumed this cycle (to arbiter `yumi_i`).
- `v_o`  out  `num_out_p`  per-channel head valid.
- `data_o`  out  `num_out_p*width_p`  per-channel head data; channel k is at bits `[k*width_p +: width_p]`.
- `ready_i`  in  `num_out_p`  per-channel consumer ready.
- `count_o`  out  `num_out_p*($clog2(els_p)+1)`  per-channel occupancy.
- `tag_err_o`  out  1  sticky flag: an out-of-range tag was presented.

## Operation
- `yumi_o = v_i & (tag_i < num_out_p) & ~full[tag_i]`.
  - Combinational from the inputs and registered state only.
  - `yumi_o` never depends on `v_i` of another cycle.
  - `yumi_o` never depends on `ready_i` (no same-cycle full bypass).
- Enqueue: when `yumi_o` is high, `data_i` is written to the tail of FIFO `tag_i`, that tail pointer advances and its count increments.
- Dequeue on channel k: when `v_o[k] & ready_i[k]`, head pointer k advances and count k decrements.
- Simultaneous enqueue and dequeue on the same channel:
  - When not empty, count is unchanged and both pointers advance.
  - When full, the enqueue is refused regardless of the dequeue.
- Enqueue into an empty FIFO does not fall through. `v_o` rises the following cycle.
- Pointers are `$clog2(els_p)` bits and wrap naturally at `els_p`. Count saturates neither high nor low; overflow and underflow are impossible by construction.
- `v_o[k] = (count[k] != 0)`. `data_o[k]` is the head entry of FIFO k. `data_o[k]` is undefined (don't-care) when `v_o[k]` is low.
- Out-of-range tag (`tag_i >= num_out_p`, only possible when `num_out_p` is not a power of two):
  - `yumi_o` stays 0 and the word is never accepted.
  - `tag_err_o` sets at the next edge and holds until reset.

## Timing
- Enqueue-to-`v_o` latency is 1 cycle. Dequeue takes effect at the next edge.
- Sustained throughput is 1 word/cycle in and 1 word/cycle per channel out.
- Reset (asynchronous assert, synchronous deassert expected from the system):
  - All counts and pointers go to 0; `v_o` goes to 0; `tag_err_o` goes to 0.
  - `yumi_o` goes to 0 during reset irrespective of `v_i`.
  - Storage contents are not reset.
- Reset mid-operation discards all buffered words. `count_o` reads 0 in the same cycle as the reset assertion.

## Structure
- Package `bsg_tag_demux_pkg`: `tag_width_lp` helper function, count-width helper, and the `num_out_p`/`els_p` legal-range constants for elaboration assertions.
- Sub-module `bsg_tag_demux_fifo_ch`, instantiated `num_out_p` times.
  - Contents: one channel's storage, pointers, count, `full`/`v_o`.
  - Ports: `enq_i`, `data_i`, `deq_i`, `full_o`, `v_o`, `data_o`, `count_o`.
- The top level holds only the tag decode, the `yumi_o` logic and `tag_err_o`.

## Test plan
- Reset, then `v_i=1, tag_i=0, data_i=16'hA5A5`:
  - `yumi_o=1` in that cycle.
  - Next cycle `v_o=2'b01`, `data_o[15:0]=16'hA5A5`, `count_o` ch0 = 1.
- Fill ch1: `ready_i=0`, three consecutive words with tag 1 (`els_p=2`):
  - `yumi_o` is 1, 1, 0.
  - ch1 count = 2; the third word remains offered.
- With ch1 full and `ready_i=2'b00`, present a tag-0 word: `yumi_o=1` immediately (no head-of-line blocking).
- ch0 full, same cycle `ready_i[0]=1` and a tag-0 word offered:
  - `yumi_o=0` (no bypass); count drops to 1.
  - Next cycle `yumi_o=1` and count stays 1.
- Stream 20 words alternating tags 0/1 with `ready_i=2'b11`:
  - 1 word/cycle accepted.
  - Per-channel order is preserved across pointer wrap.
- Assert `reset_ni=0` asynchronously with ch0 count = 2:
  - `v_o`, `count_o` and `yumi_o` go to 0 before the next edge.
  - After release, the first enqueue appears 1 cycle later.

Source files
------------

// File: rtl/bsg_tag_demux_pkg.sv
// Shared sizing helpers and legal parameter ranges for the tag demux FIFOs.
package bsg_tag_demux_pkg;

    localparam int num_out_min_lp = 2;
    localparam int num_out_max_lp = 8;
    localparam int els_min_lp     = 2;
    localparam int els_max_lp     = 16;

    // Width of the destination tag for a given channel count.
    function automatic int tag_width(input int num_out);
        return $clog2(num_out);
    endfunction

    // Width of a FIFO read/write pointer.
    function automatic int ptr_width(input int els);
        return $clog2(els);
    endfunction

    // Width of an occupancy counter; one extra bit so "full" is representable.
    function automatic int count_width(input int els);
        return $clog2(els) + 1;
    endfunction

    // True when els is a power of two.
    function automatic bit is_pow2(input int els);
        return (els > 0) && ((els & (els - 1)) == 0);
    endfunction

endpackage

// File: rtl/bsg_tag_demux_fifo_ch.sv
// One output channel: circular buffer with head/tail pointers and an
// occupancy counter. No fall-through: a word written into an empty buffer
// becomes visible on v_o one cycle later.
module bsg_tag_demux_fifo_ch
    import bsg_tag_demux_pkg::*;
#(
    parameter  int width_p        = 16,
    parameter  int els_p          = 2,
    localparam int ptr_width_lp   = ptr_width(els_p),
    localparam int count_width_lp = count_width(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      enq_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      deq_i,
    output logic                      full_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    output logic [count_width_lp-1:0] count_o
);

    logic [width_p-1:0]        mem [els_p];
    logic [ptr_width_lp-1:0]   wptr;
    logic [ptr_width_lp-1:0]   rptr;
    logic [count_width_lp-1:0] count;
    logic                      enq_ok;
    logic                      deq_ok;

    assign full_o  = (count == count_width_lp'(els_p));
    assign v_o     = (count != '0);
    assign data_o  = mem[rptr];
    assign count_o = count;

    // Local guards make overflow/underflow impossible even if the caller misbehaves.
    assign enq_ok = enq_i & ~full_o;
    assign deq_ok = deq_i & v_o;

    // Pointers wrap naturally at els_p; count moves only when exactly one side fires.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_ok) wptr <= wptr + 1'b1;
            if (deq_ok) rptr <= rptr + 1'b1;
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; stale entries are masked by v_o.
    always_ff @(posedge clk_i) begin
        if (enq_ok) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_tag_demux_fifos.sv
// Steers the arbiter's single output stream into per-tag FIFOs so that a
// stalled consumer only blocks words bound for its own channel.
//
// Handshakes: upstream is valid/yumi -- the word on data_i/tag_i is retired
// in any cycle where yumi_o is high, and yumi_o never looks at ready_i, so a
// full channel refuses even if it is draining that same cycle. Each output
// channel is valid/ready -- a word leaves channel k on an edge where both
// v_o[k] and ready_i[k] are high; v_o[k] never depends on ready_i[k].
module bsg_tag_demux_fifos
    import bsg_tag_demux_pkg::*;
#(
    parameter  int width_p        = 16,
    parameter  int num_out_p      = 2,
    parameter  int els_p          = 2,
    localparam int tag_width_lp   = tag_width(num_out_p),
    localparam int count_width_lp = count_width(els_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                v_i,
    input  logic [width_p-1:0]                  data_i,
    input  logic [tag_width_lp-1:0]             tag_i,
    output logic                                yumi_o,
    output logic [num_out_p-1:0]                v_o,
    output logic [num_out_p*width_p-1:0]        data_o,
    input  logic [num_out_p-1:0]                ready_i,
    output logic [num_out_p*count_width_lp-1:0] count_o,
    output logic                                tag_err_o
);

    if (num_out_p < num_out_min_lp || num_out_p > num_out_max_lp) begin : g_bad_num_out
        $error("bsg_tag_demux_fifos: num_out_p out of range");
    end
    if (els_p < els_min_lp || els_p > els_max_lp || !is_pow2(els_p)) begin : g_bad_els
        $error("bsg_tag_demux_fifos: els_p must be a power of two in range");
    end

    logic [num_out_p-1:0] tag_hit;
    logic [num_out_p-1:0] full;
    logic [num_out_p-1:0] enq;
    logic [num_out_p-1:0] deq;
    logic                 in_range;
    logic                 tag_full;

    // A tag beyond num_out_p matches no channel, so it can never be accepted.
    assign in_range = |tag_hit;
    assign tag_full = |(tag_hit & full);
    assign yumi_o   = reset_ni & v_i & in_range & ~tag_full;
    assign enq      = tag_hit & {num_out_p{yumi_o}};
    assign deq      = v_o & ready_i;

    for (genvar k = 0; k < num_out_p; k++) begin : g_ch
        assign tag_hit[k] = (tag_i == tag_width_lp'(k));

        bsg_tag_demux_fifo_ch #(
            .width_p (width_p),
            .els_p   (els_p)
        ) u_ch (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .enq_i    (enq[k]),
            .data_i   (data_i),
            .deq_i    (deq[k]),
            .full_o   (full[k]),
            .v_o      (v_o[k]),
            .data_o   (data_o[k*width_p +: width_p]),
            .count_o  (count_o[k*count_width_lp +: count_width_lp])
        );
    end

    // Sticky record that an unroutable tag was ever offered.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tag_err_o <= 1'b0;
        end else if (v_i && !in_range) begin
            tag_err_o <= 1'b1;
        end
    end

endmodule
